// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational on the IF-stage PC. Updates come from the MEM stage,
// which also raises mispredict with the correct redirect PC.
// Optional build macro: BPU_STATS_EN adds resolved-update and mispredict counters.
module branch_predictor #(
    parameter int unsigned  ENTRIES = 16,
    localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_mispredicts
);

    localparam int unsigned TAG_W = 30 - IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [29:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] upd_idx;
    logic             if_hit;
    logic             upd_hit;

    assign if_idx  = if_pc[IDX_W+1:2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign if_hit  = valid_q[if_idx] && (tag_q[if_idx] == if_pc[31:IDX_W+2]);
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_pc[31:IDX_W+2]);

    // Prediction from registered table state; no bypass from a same-cycle update.
    always_comb begin
        pred_taken  = if_hit && ctr_q[if_idx][1];
        pred_target = pred_taken ? {target_q[if_idx], 2'b00} : if_pc + 32'd4;
    end

    // Resolution check against what was predicted when the instruction was fetched.
    always_comb begin
        mispredict  = upd_valid && ((upd_pred_taken != upd_taken) ||
                                    (upd_taken && (upd_pred_target != upd_target)));
        redirect_pc = (upd_valid && upd_taken) ? upd_target : upd_pc + 32'd4;
    end

    // Table update: train counters on hits, allocate only on taken misses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    if (ctr_q[upd_idx] != 2'b11) begin
                        ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
                    end
                    target_q[upd_idx] <= upd_target[31:2];
                end else if (ctr_q[upd_idx] != 2'b00) begin
                    ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_pc[31:IDX_W+2];
                target_q[upd_idx] <= upd_target[31:2];
                ctr_q[upd_idx]    <= 2'b10;
            end
        end
    end

`ifdef BPU_STATS_EN
    logic [31:0] lookups_q;
    logic [31:0] mispredicts_q;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lookups_q     <= '0;
            mispredicts_q <= '0;
        end else begin
            if (upd_valid) begin
                lookups_q <= lookups_q + 32'd1;
            end
            if (mispredict) begin
                mispredicts_q <= mispredicts_q + 32'd1;
            end
        end
    end

    assign stat_lookups     = lookups_q;
    assign stat_mispredicts = mispredicts_q;
`else
    assign stat_lookups     = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=16) with an expected-value scoreboard.
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] stat_lookups;
    logic [31:0] stat_mispredicts;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_item_t;

    sb_item_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_upd    = 0;
    int n_misp   = 0;

    branch_predictor #(.ENTRIES(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_target  (upd_pred_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .stat_lookups     (stat_lookups),
        .stat_mispredicts (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] val);
        sb_item_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        sb_item_t e;
        n_checks++;
        if (sb.size() == 0) begin
            e.tag = "empty";
            e.val = 'x;
        end else begin
            e = sb.pop_front();
        end
        assert (e.tag == tag && obs === e.val) n_pass++;
        else $error("FAIL %s: observed %h expected %h (scoreboard tag %s)", tag, obs, e.val, e.tag);
    endtask

    task automatic lookup(input logic [31:0] pc, input logic exp_t, input logic [31:0] exp_tgt);
        if_pc = pc;
        push("pred_taken", {31'd0, exp_t});
        push("pred_target", exp_tgt);
        #1;
        check("pred_taken", {31'd0, pred_taken});
        check("pred_target", pred_target);
    endtask

    task automatic check_stats();
`ifdef BPU_STATS_EN
        push("stat_lookups", n_upd);
        push("stat_mispredicts", n_misp);
`else
        push("stat_lookups", 32'd0);
        push("stat_mispredicts", 32'd0);
`endif
        check("stat_lookups", stat_lookups);
        check("stat_mispredicts", stat_mispredicts);
    endtask

    // Drive an update and check the combinational resolution outputs.
    task automatic drive_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                             input logic ptk, input logic [31:0] ptgt,
                             input logic exp_m, input logic [31:0] exp_r);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
        push("mispredict", {31'd0, exp_m});
        push("redirect_pc", exp_r);
        #1;
        check("mispredict", {31'd0, mispredict});
        check("redirect_pc", redirect_pc);
        n_upd++;
        if (exp_m) n_misp++;
    endtask

    task automatic commit();
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt,
                          input logic exp_m, input logic [31:0] exp_r);
        drive_upd(pc, tk, tgt, ptk, ptgt, exp_m, exp_r);
        commit();
    endtask

    initial begin
        reset = 1'b1;
        if_pc = 32'h0;
        upd_valid = 1'b0;
        upd_pc = 32'h0;
        upd_taken = 1'b0;
        upd_target = 32'h0;
        upd_pred_taken = 1'b0;
        upd_pred_target = 32'h0;

        // Outputs while held in reset
        #2;
        lookup(32'h0000_3010, 1'b0, 32'h0000_3014);
        check_stats();
        #8 reset = 1'b0;
        @(posedge clk);
        #1;

        // First allocation
        lookup(32'h0000_3010, 1'b0, 32'h0000_3014);
        update(32'h0000_3010, 1'b1, 32'h0000_3000, 1'b0, 32'h0000_3014, 1'b1, 32'h0000_3000);
        lookup(32'h0000_3010, 1'b1, 32'h0000_3000);

        // Saturate up to 11
        for (int i = 0; i < 4; i++) begin
            update(32'h0000_3010, 1'b1, 32'h0000_3000, 1'b1, 32'h0000_3000, 1'b0, 32'h0000_3000);
        end
        // 11 -> 10: still taken
        update(32'h0000_3010, 1'b0, 32'h0000_3000, 1'b1, 32'h0000_3000, 1'b1, 32'h0000_3014);
        lookup(32'h0000_3010, 1'b1, 32'h0000_3000);
        // 10 -> 01: not taken
        update(32'h0000_3010, 1'b0, 32'h0000_3000, 1'b1, 32'h0000_3000, 1'b1, 32'h0000_3014);
        lookup(32'h0000_3010, 1'b0, 32'h0000_3014);
        // Saturate down to 00
        for (int i = 0; i < 3; i++) begin
            update(32'h0000_3010, 1'b0, 32'h0000_3000, 1'b0, 32'h0000_3014, 1'b0, 32'h0000_3014);
        end
        // 00 -> 01: still not taken
        update(32'h0000_3010, 1'b1, 32'h0000_3000, 1'b0, 32'h0000_3014, 1'b1, 32'h0000_3000);
        lookup(32'h0000_3010, 1'b0, 32'h0000_3014);
        // 01 -> 10: taken again
        update(32'h0000_3010, 1'b1, 32'h0000_3000, 1'b0, 32'h0000_3014, 1'b1, 32'h0000_3000);
        lookup(32'h0000_3010, 1'b1, 32'h0000_3000);

        // Target-only mispredict rewrites the stored target
        update(32'h0000_3010, 1'b1, 32'h0000_3040, 1'b1, 32'h0000_3000, 1'b1, 32'h0000_3040);
        lookup(32'h0000_3010, 1'b1, 32'h0000_3040);

        // Same-cycle lookup and update: old contents now, new contents next cycle
        if_pc = 32'h0000_3010;
        drive_upd(32'h0000_3010, 1'b1, 32'h0000_3080, 1'b1, 32'h0000_3040, 1'b1, 32'h0000_3080);
        lookup(32'h0000_3010, 1'b1, 32'h0000_3040);
        commit();
        lookup(32'h0000_3010, 1'b1, 32'h0000_3080);

        // Alias on index 4 evicts the previous occupant
        update(32'h0000_3410, 1'b1, 32'h0000_3400, 1'b0, 32'h0000_3414, 1'b1, 32'h0000_3400);
        lookup(32'h0000_3010, 1'b0, 32'h0000_3014);
        lookup(32'h0000_3410, 1'b1, 32'h0000_3400);

        // Not-taken miss does not allocate
        update(32'h0000_3020, 1'b0, 32'h0000_3100, 1'b0, 32'h0000_3024, 1'b0, 32'h0000_3024);
        lookup(32'h0000_3020, 1'b0, 32'h0000_3024);

        // upd_valid=0: no mispredict, fall-through redirect, no state change
        upd_pc = 32'h0000_3010;
        upd_taken = 1'b1;
        upd_target = 32'h0000_3999;
        upd_pred_taken = 1'b0;
        push("mispredict", 32'd0);
        push("redirect_pc", 32'h0000_3014);
        #1;
        check("mispredict", {31'd0, mispredict});
        check("redirect_pc", redirect_pc);
        @(posedge clk);
        #1;
        lookup(32'h0000_3010, 1'b0, 32'h0000_3014);

        // 32-bit wrap of the fall-through PC
        lookup(32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
        upd_pc = 32'hFFFF_FFFC;
        upd_taken = 1'b0;
        push("redirect_pc", 32'h0000_0000);
        #1;
        check("redirect_pc", redirect_pc);

        check_stats();

        // Asynchronous reset mid-update: update discarded, everything misses at once
        drive_upd(32'h0000_3020, 1'b1, 32'h0000_3200, 1'b0, 32'h0000_3024, 1'b1, 32'h0000_3200);
        n_upd = 0;
        n_misp = 0;
        reset = 1'b1;
        #1;
        lookup(32'h0000_3410, 1'b0, 32'h0000_3414);
        check_stats();
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        reset = 1'b0;
        lookup(32'h0000_3020, 1'b0, 32'h0000_3024);

        // Ten updates, three of them mispredicted
        for (int i = 0; i < 7; i++) begin
            update(32'h0000_3030, 1'b0, 32'h0, 1'b0, 32'h0000_3034, 1'b0, 32'h0000_3034);
        end
        for (int i = 0; i < 3; i++) begin
            update(32'h0000_3040, 1'b0, 32'h0, 1'b1, 32'h0000_3500, 1'b1, 32'h0000_3044);
        end
        check_stats();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
